imgproc_cfg_sequencer: RTL and testbench
========================================

Name: imgproc_cfg_sequencer

Overview:
Frame-synchronous configuration controller for the EEE image-processing block.
- Software/switch logic writes threshold and mode values into shadow registers at any time.
- The block commits only the changed ("dirty") registers to the image processor's Avalon-MM slave, starting at the next camera start-of-frame.
- The datapath therefore never sees a configuration change mid-frame.
- Sits between the Nios-side control logic and the image processor's register slave, in the camera pixel-processing clock domain.

Parameters:
NUM_REGS, 8, number of shadow/config registers.
ADDR_W, 3, shadow index width; must equal clog2(NUM_REGS).
DATA_W, 32, config register width.
AV_ADDR_BASE, 0, Avalon word address of image-processor register 0.

Ports:
clk  in  1  single clock, shared with the image processor slave.
reset  in  1  synchronous, active-high.
fval  in  1  camera frame-valid, already synchronous to clk.
cfg_wr  in  1  shadow write strobe.
cfg_addr  in  ADDR_W  shadow index.
cfg_data  in  DATA_W  shadow write data.
m_address  out  ADDR_W+1  Avalon-MM master address, equal to AV_ADDR_BASE+idx.
m_write  out  1  Avalon write request.
m_writedata  out  DATA_W  Avalon write data.
m_waitrequest  in  1  Avalon slave stall.
busy  out  1  high while a commit is in progress.
overrun_cnt  out  8  saturating count of start-of-frame events missed because a commit was still running.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - Shadows, snapshot, dirty mask and pending mask all 0.
  - m_write=0, m_address=0, m_writedata=0, busy=0, overrun_cnt=0.
  - fval_d resets to 1, so an fval already high at reset release does not produce a spurious start-of-frame.
- Start-of-frame: sof = fval & ~fval_d; fval_d is registered every cycle.
- Shadow write (cfg_wr):
  - shadow[cfg_addr] <= cfg_data and dirty[cfg_addr] <= 1, accepted in every state.
  - Last write before a sof wins; repeated writes to one register produce one bus write.
- FSM states: IDLE, SCAN, WRITE.
  - IDLE, sof & |dirty: snapshot <= shadow, pending <= dirty, dirty <= 0; go to SCAN.
    - A cfg_wr in the same cycle re-sets its dirty bit after the clear and lands in the snapshot of the next frame, not this one.
  - IDLE, sof & ~|dirty: stay in IDLE; no bus activity.
  - SCAN: idx <= lowest set bit of pending.
    - pending==0: go to IDLE.
    - Otherwise: load m_address/m_writedata, set m_write=1, go to WRITE.
  - WRITE: hold m_write, m_address and m_writedata stable while m_waitrequest=1.
    - On m_waitrequest=0 the write is accepted: m_write <= 0, pending[idx] <= 0, go to SCAN.
- Latency and timing:
  - Let cycle t be the cycle where sof=1.
  - SCAN at t+1; first m_write high at t+2.
  - With no stall, each register costs 2 cycles; the last accept is at t+2*k for k dirty registers.
  - busy = (state != IDLE): it rises at t+1 and falls the cycle after the final SCAN finds pending==0.
- Overrun:
  - A sof while state != IDLE increments overrun_cnt, saturating at 255.
  - The running commit is not aborted, and the missed sof is not queued.
  - Dirty registers wait for the following sof.
- Snapshot isolation: cfg_wr during a commit modifies only the shadow and dirty mask; the in-flight snapshot is never changed.
- Reset mid-commit:
  - m_write drops to 0 in the next cycle; the in-flight write is abandoned and all dirty state is lost.
  - Acceptable, because the slave is reset on the same reset.
- Avalon rules:
  - m_write never deasserts while m_waitrequest=1.
  - Address and data never change while m_write=1.

Decomposition:
- Package imgproc_cfg_pkg holds:
  - NUM_REGS, ADDR_W and DATA_W defaults.
  - The state enum {IDLE, SCAN, WRITE}.
  - OVR_MAX=255.
- One natural sub-module: pri_enc_lsb, a parameterised lowest-set-bit priority encoder (pending mask -> idx plus a valid flag).

Test Plan:
1. fval=1 held through reset, then released with no cfg_wr -> no m_write for 100 cycles; busy=0; overrun_cnt=0.
2. cfg_wr reg2=0x000000A5 and reg5=0x00001234, then fval rises (sof at t), waitrequest=0 -> m_write at t+2 (addr 2, data 0xA5) and t+4 (addr 5, data 0x1234); busy low at t+6.
3. As in scenario 2, but waitrequest=1 for 3 cycles on the first write -> addr/data/m_write stable throughout; second write shifts to t+7.
4. During the scenario-2 commit, cfg_wr reg2=0xFF -> current burst still writes 0xA5; the next sof writes only reg2=0xFF.
5. waitrequest held 50 cycles while fval toggles to give a sof at cycle 20 -> overrun_cnt=1 and the commit completes.
   - Forced 300 overruns -> overrun_cnt=255.
6. Two cfg_wr to reg7 (0x1, then 0x2) before sof -> exactly one bus write, addr 7, data 0x2.
   - A later sof with no dirty registers -> no writes.

Source files
------------

// File: rtl/imgproc_cfg_pkg.sv
// Shared types and defaults for the frame-synchronous image-processor config sequencer.
package imgproc_cfg_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int DATA_W_DEF   = 32;
  localparam int OVR_MAX      = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/pri_enc_lsb.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// asserted request bit and a flag telling whether any bit was set at all.
module pri_enc_lsb #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imgproc_cfg_sequencer.sv
// Frame-synchronous configuration sequencer: shadow registers are written at any
// time, and only the dirty ones are pushed to the image processor's Avalon-MM
// slave, starting at the next camera start-of-frame.
module imgproc_cfg_sequencer
  import imgproc_cfg_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int AV_ADDR_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fval,
  input  logic              cfg_wr,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic [ADDR_W:0]   m_address,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  state_e              state_q, state_d;
  logic                fval_d_q, fval_d_d;
  logic [DATA_W-1:0]   shadow_q   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d   [NUM_REGS];
  logic [DATA_W-1:0]   snapshot_q [NUM_REGS];
  logic [DATA_W-1:0]   snapshot_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                m_write_q, m_write_d;
  logic [ADDR_W:0]     m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
  logic [7:0]          overrun_cnt_q, overrun_cnt_d;

  logic                sof;
  logic [ADDR_W-1:0]   enc_idx;
  logic                enc_valid;

  pri_enc_lsb #(
    .N     (NUM_REGS),
    .IDX_W (ADDR_W)
  ) u_pri_enc (
    .req   (pending_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign sof = fval & ~fval_d_q;

  // Next-state logic: commit FSM, overrun counter and shadow/dirty bookkeeping.
  always_comb begin
    state_d       = state_q;
    fval_d_d      = fval;
    shadow_d      = shadow_q;
    snapshot_d    = snapshot_q;
    dirty_d       = dirty_q;
    pending_d     = pending_q;
    idx_d         = idx_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    overrun_cnt_d = overrun_cnt_q;

    // A frame that starts while a commit is still running is counted, not queued.
    if (sof && (state_q != IDLE) && (overrun_cnt_q != 8'(OVR_MAX))) begin
      overrun_cnt_d = overrun_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (sof && (|dirty_q)) begin
          snapshot_d = shadow_q;
          pending_d  = dirty_q;
          dirty_d    = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (!enc_valid) begin
          state_d = IDLE;
        end else begin
          idx_d         = enc_idx;
          m_address_d   = (ADDR_W + 1)'(AV_ADDR_BASE) + (ADDR_W + 1)'(enc_idx);
          m_writedata_d = snapshot_q[enc_idx];
          m_write_d     = 1'b1;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        // Address, data and write stay put until the slave stops stalling.
        if (!m_waitrequest) begin
          m_write_d        = 1'b0;
          pending_d[idx_q] = 1'b0;
          state_d          = SCAN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Applied after the commit clear so a same-cycle write stays dirty for the next frame.
    if (cfg_wr) begin
      shadow_d[cfg_addr] = cfg_data;
      dirty_d[cfg_addr]  = 1'b1;
    end
  end

  // State register with synchronous reset; fval_d resets high to mask a frame already in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fval_d_q      <= 1'b1;
      dirty_q       <= '0;
      pending_q     <= '0;
      idx_q         <= '0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      overrun_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i]   <= '0;
        snapshot_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fval_d_q      <= fval_d_d;
      dirty_q       <= dirty_d;
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      overrun_cnt_q <= overrun_cnt_d;
      shadow_q      <= shadow_d;
      snapshot_q    <= snapshot_d;
    end
  end

  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;
  assign busy        = (state_q != IDLE);
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_imgproc_cfg_sequencer.sv
// Self-checking bench for imgproc_cfg_sequencer: directed frame scenarios plus a
// randomized phase, checked by a behavioural model and an expected-write scoreboard.
module tb_imgproc_cfg_sequencer;

  localparam int NR   = 8;
  localparam int AW   = 3;
  localparam int DW   = 32;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          fval;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [AW:0]   m_address;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_waitrequest;
  logic          busy;
  logic [7:0]    overrun_cnt;

  imgproc_cfg_sequencer #(
    .NUM_REGS     (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .AV_ADDR_BASE (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fval          (fval),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  // Scoreboard and reference model state (owned by the monitor process).
  wr_t           exp_q[$];
  logic [DW-1:0] mdl_shadow [NR];
  logic [NR-1:0] mdl_dirty;
  bit            mdl_fval_prev;
  bit            mdl_busy;
  int            mdl_ovr;
  int            remaining;
  int            wr_due;
  int            idle_at;
  int            cyc;
  int            n_vec;
  int            n_bad;
  int            drain_cnt;
  bit            prev_rst;
  bit            prev_mw;
  bit            prev_wait;
  logic [AW:0]   prev_addr;
  logic [DW-1:0] prev_data;

  // Stimulus control (owned by the stimulus process).
  bit hold_wait;
  bit rand_wait;
  int stall_left;
  bit end_req;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: samples on the falling edge, compares DUT against the model, then advances the model.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < NR; i++) mdl_shadow[i] = '0;
      mdl_dirty     = '0;
      mdl_fval_prev = 1'b1;
      mdl_busy      = 1'b0;
      mdl_ovr       = 0;
      remaining     = 0;
      wr_due        = -1;
      idle_at       = -1;
      prev_rst      = 1'b1;
      prev_mw       = 1'b0;
      prev_wait     = 1'b0;
    end else begin
      bit sof;
      bit next_busy;
      cyc++;

      if (prev_rst) begin
        chk("reset_m_write", 64'(m_write), 64'd0);
        chk("reset_m_address", 64'(m_address), 64'd0);
        chk("reset_m_writedata", 64'(m_writedata), 64'd0);
      end

      chk("busy", 64'(busy), 64'(mdl_busy));
      chk("overrun_cnt", 64'(overrun_cnt), 64'(mdl_ovr));

      if (m_write && !prev_mw) chk("write_start_cycle", 64'(cyc), 64'(wr_due));
      if (prev_mw && prev_wait) begin
        chk("write_held_in_stall", 64'(m_write), 64'd1);
        chk("addr_stable_in_stall", 64'(m_address), 64'(prev_addr));
        chk("data_stable_in_stall", 64'(m_writedata), 64'(prev_data));
      end

      if (m_write && !m_waitrequest) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                   m_address, m_writedata, cyc);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(m_address), 64'(e.addr));
          chk("write_data", 64'(m_writedata), 64'(e.data));
        end
        if (remaining > 0) remaining--;
        if (remaining == 0) begin
          idle_at = cyc + 2;
          wr_due  = -1;
        end else begin
          wr_due = cyc + 2;
        end
      end

      // Model advance: frame start, commit launch, overrun, shadow writes.
      sof           = fval && !mdl_fval_prev;
      mdl_fval_prev = fval;
      next_busy     = mdl_busy;
      if (mdl_busy && (cyc + 1 == idle_at)) next_busy = 1'b0;
      if (sof) begin
        if (mdl_busy) begin
          mdl_ovr = (mdl_ovr + 1 > 255) ? 255 : mdl_ovr + 1;
        end else if (mdl_dirty != '0) begin
          remaining = 0;
          for (int i = 0; i < NR; i++) begin
            if (mdl_dirty[i]) begin
              exp_q.push_back('{addr: (AW + 1)'(BASE + i), data: mdl_shadow[i]});
              remaining++;
            end
          end
          mdl_dirty = '0;
          next_busy = 1'b1;
          wr_due    = cyc + 2;
          idle_at   = -1;
        end
      end
      if (cfg_wr) begin
        mdl_shadow[cfg_addr] = cfg_data;
        mdl_dirty[cfg_addr]  = 1'b1;
      end
      mdl_busy = next_busy;

      prev_rst  = 1'b0;
      prev_mw   = m_write;
      prev_wait = m_waitrequest;
      prev_addr = m_address;
      prev_data = m_writedata;

      if (cyc > 40000) begin
        $display("FAIL watchdog: got %0d cycles, expected end before 40000", cyc);
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end

      if (end_req) begin
        drain_cnt++;
        if (!mdl_busy && !busy && exp_q.size() == 0) begin
          chk("final_overrun_cnt", 64'(overrun_cnt), 64'(mdl_ovr));
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
          $finish;
        end else if (drain_cnt > 200) begin
          n_vec++;
          n_bad++;
          $display("FAIL drain: got %0d writes outstanding, busy=%0d, expected 0 and idle", exp_q.size(), busy);
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
          $finish;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
    if (hold_wait) m_waitrequest = 1'b1;
    else if (stall_left > 0 && m_write) begin
      m_waitrequest = 1'b1;
      stall_left--;
    end else if (rand_wait) m_waitrequest = ($urandom_range(0, 2) == 0);
    else m_waitrequest = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic write_shadow(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    next_cycle();
  endtask

  task automatic frame_start();
    fval = 1'b0;
    next_cycle();
    fval = 1'b1;
    next_cycle();
  endtask

  initial begin
    reset         = 1'b1;
    fval          = 1'b1;
    cfg_wr        = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    m_waitrequest = 1'b0;
    hold_wait     = 1'b0;
    rand_wait     = 1'b0;
    stall_left    = 0;
    end_req       = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // fval high across reset release, nothing dirty: quiet bus.
    idle(100);

    // Two dirty registers, no stall.
    write_shadow(3'd2, 32'h0000_00A5);
    write_shadow(3'd5, 32'h0000_1234);
    frame_start();
    idle(10);

    // Same, with a three-cycle stall on the first write.
    write_shadow(3'd2, 32'h0000_00A5);
    write_shadow(3'd5, 32'h0000_1234);
    stall_left = 3;
    frame_start();
    idle(12);

    // Shadow rewrite during a commit lands in the following frame only.
    write_shadow(3'd2, 32'h0000_00A5);
    write_shadow(3'd5, 32'h0000_1234);
    frame_start();
    write_shadow(3'd2, 32'h0000_00FF);
    idle(10);
    frame_start();
    idle(10);

    // Repeated writes collapse to one bus write; an empty frame writes nothing.
    write_shadow(3'd7, 32'h0000_0001);
    write_shadow(3'd7, 32'h0000_0002);
    frame_start();
    idle(10);
    frame_start();
    idle(10);

    // Write issued in the same cycle as the start-of-frame goes to the next frame.
    write_shadow(3'd1, 32'h1111_1111);
    fval = 1'b0;
    next_cycle();
    fval = 1'b1;
    write_shadow(3'd4, 32'h4444_4444);
    idle(10);
    frame_start();
    idle(10);

    // Long stall with a frame start in the middle: one overrun, commit completes.
    write_shadow(3'd3, 32'hCAFE_0003);
    hold_wait = 1'b1;
    frame_start();
    idle(18);
    frame_start();
    idle(30);
    hold_wait = 1'b0;
    idle(10);

    // Many overruns saturate the counter.
    write_shadow(3'd0, 32'hDEAD_BEEF);
    hold_wait = 1'b1;
    frame_start();
    repeat (300) frame_start();
    hold_wait = 1'b0;
    idle(10);

    // Randomized traffic: writes, frame toggles and stalls.
    rand_wait = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_wr   = 1'b1;
        cfg_addr = AW'($urandom_range(0, NR - 1));
        cfg_data = $urandom();
      end
      if ($urandom_range(0, 11) == 0) fval = ~fval;
      next_cycle();
    end
    rand_wait = 1'b0;
    fval      = 1'b1;
    end_req   = 1'b1;
    forever next_cycle();
  end

endmodule
